tx_frame_receiver: RTL and testbench

//  Receive end of the TX_data parametric serial link: deserialises UART 8N1 bytes,

---
 rtl/tx_frame_receiver_pkg.sv | 33 +++
 rtl/tx_frame_receiver_uart_rx_byte.sv | 111 +++++++++++
 rtl/tx_frame_receiver.sv | 175 +++++++++++++++++
 tb/tb_tx_frame_receiver.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_frame_receiver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_frame_receiver_pkg
//  Description : Shared constants and state encodings for the TX_data link
//                receiver: sync byte values, default bit divider, parser and
//                byte-receiver state enums.
//  Revision    : 1.0  initial release
// ============================================================================
package tx_frame_receiver_pkg;

    localparam int         c_def_clk_div = 434;
    localparam logic [7:0] c_sync_hi     = 8'hA5;
    localparam logic [7:0] c_sync_lo     = 8'h5A;

    // Frame parser states
    typedef enum logic [2:0] {
        P_HUNT  = 3'd0,
        P_SYNC2 = 3'd1,
        P_HI    = 3'd2,
        P_LO    = 3'd3,
        P_CSUM  = 3'd4
    } parser_state_t;

    // UART byte receiver states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/tx_frame_receiver_uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_byte
//  Description : UART 8N1 byte deserialiser working on an already
//                synchronised line. Start bit re-checked at half a bit,
//                data and stop sampled mid-bit, LSB first.
//  Ports       : clock     in   system clock
//                reset     in   asynchronous, active-low
//                rx_sync   in   synchronised serial line (idles high)
//                data      out  last received byte
//                byte_vld  out  1-cycle pulse, good byte (stop=1)
//                frame_bad out  1-cycle pulse, stop bit sampled low
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_byte
    import tx_frame_receiver_pkg::*;
#(
    parameter int CLK_DIV = c_def_clk_div
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_sync,
    output logic [7:0] data,
    output logic       byte_vld,
    output logic       frame_bad
);

    localparam int              CNT_W  = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] c_half = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] c_full = CNT_W'(CLK_DIV - 1);

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             prev_q, prev_d;
    logic             vld_q, vld_d;
    logic             bad_q, bad_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        prev_d  = rx_sync;
        vld_d   = 1'b0;
        bad_d   = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                // Edge-triggered so a line held low after a framing error
                // cannot start a phantom byte.
                if (prev_q && !rx_sync) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == c_half) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == c_full) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == c_full) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    vld_d   = rx_sync;
                    bad_d   = !rx_sync;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            prev_q  <= 1'b1;
            vld_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            prev_q  <= prev_d;
            vld_q   <= vld_d;
            bad_q   <= bad_d;
        end
    end

    assign data      = shift_q;
    assign byte_vld  = vld_q;
    assign frame_bad = bad_q;

endmodule
`default_nettype wire

// File: rtl/tx_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tx_frame_receiver
//  Description : Receive end of the TX_data serial link. Synchronises rx,
//                deserialises bytes, hunts the sync pair, writes 16-bit
//                big-endian words and checks the additive byte checksum.
//  Ports       : clock     in   system clock
//                reset     in   asynchronous, active-low
//                rx        in   serial line, idles high, asynchronous
//                wr_en     out  1-cycle write strobe
//                wr_addr   out  word index in frame
//                wr_data   out  {hi_byte, lo_byte}
//                frame_ok  out  1-cycle pulse, good frame
//                frame_err out  1-cycle pulse, aborted frame
//                frame_cnt out  good frame count mod 16
//  Revision    : 1.0  initial release
// ============================================================================
module tx_frame_receiver
    import tx_frame_receiver_pkg::*;
#(
    parameter int         CLK_DIV = c_def_clk_div,
    parameter int         WORDS   = 256,
    parameter int         ADDR_W  = 9,
    parameter int         TIMEOUT = 20,
    parameter logic [7:0] SYNC_HI = c_sync_hi,
    parameter logic [7:0] SYNC_LO = c_sync_lo
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [3:0]        frame_cnt
);

    localparam int TMO_LIMIT = TIMEOUT * CLK_DIV;
    localparam int TMR_W     = $clog2(TMO_LIMIT + 1);

    logic [1:0]        sync_q, sync_d;
    logic [7:0]        rx_data;
    logic              byte_vld;
    logic              frame_bad;

    parser_state_t     state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        hi_q, hi_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              frame_ok_q, frame_ok_d;
    logic              frame_err_q, frame_err_d;
    logic [3:0]        frame_cnt_q, frame_cnt_d;

    assign sync_d = {sync_q[0], rx};

    uart_rx_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .clock     (clock),
        .reset     (reset),
        .rx_sync   (sync_q[1]),
        .data      (rx_data),
        .byte_vld  (byte_vld),
        .frame_bad (frame_bad)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        hi_d        = hi_q;
        timer_d     = (state_q == P_HUNT) ? '0 : timer_q + TMR_W'(1);
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;

        if (frame_bad) begin
            if (state_q != P_HUNT) begin
                state_d     = P_HUNT;
                frame_err_d = 1'b1;
            end
        end else if (byte_vld) begin
            // byte_vld is checked before the timeout so a byte landing on
            // the final timer cycle still counts.
            timer_d = '0;
            case (state_q)
                P_HUNT: begin
                    if (rx_data == SYNC_HI) state_d = P_SYNC2;
                end
                P_SYNC2: begin
                    if (rx_data == SYNC_LO) begin
                        state_d = P_HI;
                        idx_d   = '0;
                        sum_d   = 8'h00;
                    end else if (rx_data != SYNC_HI) begin
                        state_d = P_HUNT;
                    end
                end
                P_HI: begin
                    hi_d    = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = P_LO;
                end
                P_LO: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = {hi_q, rx_data};
                    sum_d     = sum_q + rx_data;
                    idx_d     = idx_q + ADDR_W'(1);
                    state_d   = (idx_q == ADDR_W'(WORDS - 1)) ? P_CSUM : P_HI;
                end
                P_CSUM: begin
                    if (rx_data == sum_q) begin
                        frame_ok_d  = 1'b1;
                        frame_cnt_d = frame_cnt_q + 4'd1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = P_HUNT;
                end
                default: state_d = P_HUNT;
            endcase
        end else if ((state_q != P_HUNT) && (timer_q >= TMR_W'(TMO_LIMIT - 1))) begin
            state_d     = P_HUNT;
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q      <= 2'b11;
            state_q     <= P_HUNT;
            idx_q       <= '0;
            sum_q       <= 8'h00;
            hi_q        <= 8'h00;
            timer_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 16'h0000;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= 4'd0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            hi_q        <= hi_d;
            timer_q     <= timer_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_frame_receiver
//  Description : Self-checking bench for tx_frame_receiver (CLK_DIV=8,
//                WORDS=4). Table of whole-frame vectors plus directed
//                sequences for glitch, timeout and mid-frame reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tx_frame_receiver;

    localparam int CLK_DIV = 8;
    localparam int WORDS   = 4;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 20;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              rx    = 1'b1;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              frame_ok;
    logic              frame_err;
    logic [3:0]        frame_cnt;

    always #5 clock = ~clock;

    tx_frame_receiver #(
        .CLK_DIV (CLK_DIV),
        .WORDS   (WORDS),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT),
        .SYNC_HI (8'hA5),
        .SYNC_LO (8'h5A)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    // ---------------------------------------------------------------- monitor
    int                cyc     = 0;
    int                ok_n    = 0;
    int                err_n   = 0;
    int                vld_n   = 0;
    int                err_cyc = 0;
    int                vld_cyc = 0;
    logic [ADDR_W-1:0] wa_log[$];
    logic [15:0]       wd_log[$];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (wr_en) begin
            wa_log.push_back(wr_addr);
            wd_log.push_back(wr_data);
        end
        if (frame_ok) ok_n++;
        if (frame_err) begin
            err_n++;
            err_cyc = cyc;
        end
        if (dut.byte_vld) begin
            vld_n++;
            vld_cyc = cyc;
        end
    end

    // ---------------------------------------------------------------- helpers
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic line_bit(input logic v);
        rx = v;
        repeat (CLK_DIV) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        line_bit(1'b0);
        for (int i = 0; i < 8; i++) line_bit(b[i]);
        line_bit(stop);
        line_bit(1'b1);
    endtask

    typedef struct {
        string           name;
        bit              lead;     // prepend FF A5 before the sync pair
        logic [3:0][15:0] w;       // payload words, w[0] sent first
        logic [7:0]      cs;
        int              bad;      // payload byte index with stop=0, -1 none
        int              nwr;
        int              ok;
        int              err;
    } vec_t;

    task automatic send_frame(input vec_t v);
        logic [15:0] wd;
        if (v.lead) begin
            send_byte(8'hFF, 1'b1);
            send_byte(8'hA5, 1'b1);
        end
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b1);
        for (int i = 0; i < 2 * WORDS; i++) begin
            wd = v.w[i / 2];
            send_byte((i % 2 == 0) ? wd[15:8] : wd[7:0], (i != v.bad));
        end
        send_byte(v.cs, 1'b1);
    endtask

    function automatic vec_t mk(input string name, input bit lead,
                                input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2, input logic [15:0] w3,
                                input logic [7:0] cs, input int bad,
                                input int nwr, input int ok, input int err);
        vec_t v;
        v.name = name;
        v.lead = lead;
        v.w    = {w3, w2, w1, w0};
        v.cs   = cs;
        v.bad  = bad;
        v.nwr  = nwr;
        v.ok   = ok;
        v.err  = err;
        return v;
    endfunction

    // ---------------------------------------------------------------- test
    vec_t vecs[5];
    int   exp_cnt;
    int   ws, ok0, err0, vld0, lat;

    initial begin
        // Payload 12 34 56 78 9A BC DE F0 sums to 0x438 -> checksum 0x38.
        vecs[0] = mk("good",      0, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 8'h38, -1, 4, 1, 0);
        vecs[1] = mk("bad_csum",  0, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 8'h39, -1, 4, 0, 1);
        vecs[2] = mk("lead_in",   1, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 8'h38, -1, 4, 1, 0);
        vecs[3] = mk("stop_err",  0, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 8'h38,  2, 1, 0, 1);
        // Sync values as payload: A5+5A+A5+5A+00+00+00+01 = 0x1FF -> 0xFF.
        vecs[4] = mk("sync_data", 0, 16'hA55A, 16'hA55A, 16'h0000, 16'h0001, 8'hFF, -1, 4, 1, 0);
        exp_cnt = 0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst wr_en",     {31'd0, wr_en},     32'd0);
        check("rst wr_addr",   {28'd0, wr_addr},   32'd0);
        check("rst wr_data",   {16'd0, wr_data},   32'd0);
        check("rst frame_ok",  {31'd0, frame_ok},  32'd0);
        check("rst frame_err", {31'd0, frame_err}, 32'd0);
        check("rst frame_cnt", {28'd0, frame_cnt}, 32'd0);
        reset = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clock);

        // Table-driven whole frames
        for (int n = 0; n < 5; n++) begin
            ws   = wa_log.size();
            ok0  = ok_n;
            err0 = err_n;
            send_frame(vecs[n]);
            repeat (3 * CLK_DIV) @(negedge clock);
            check({vecs[n].name, " writes"}, wa_log.size() - ws, vecs[n].nwr);
            for (int k = 0; k < WORDS; k++) begin
                if (k < vecs[n].nwr && ws + k < wa_log.size()) begin
                    check($sformatf("%s addr%0d", vecs[n].name, k), {28'd0, wa_log[ws + k]}, k);
                    check($sformatf("%s data%0d", vecs[n].name, k), {16'd0, wd_log[ws + k]}, {16'd0, vecs[n].w[k]});
                end
            end
            check({vecs[n].name, " ok"},  ok_n - ok0,   vecs[n].ok);
            check({vecs[n].name, " err"}, err_n - err0, vecs[n].err);
            exp_cnt = (exp_cnt + vecs[n].ok) % 16;
            check({vecs[n].name, " cnt"}, {28'd0, frame_cnt}, exp_cnt);
        end

        // 3-clock glitch while idle must not produce a byte
        vld0 = vld_n;
        err0 = err_n;
        rx = 1'b0;
        repeat (3) @(negedge clock);
        rx = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clock);
        check("glitch bytes", vld_n - vld0, 0);
        check("glitch err",   err_n - err0, 0);

        // Timeout after 5 payload bytes
        ws   = wa_log.size();
        ok0  = ok_n;
        err0 = err_n;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h9A, 1'b1);
        repeat (21 * CLK_DIV) @(negedge clock);
        check("tmo writes", wa_log.size() - ws, 2);
        check("tmo err",    err_n - err0, 1);
        check("tmo ok",     ok_n - ok0, 0);
        lat = err_cyc - vld_cyc;
        checks++;
        if (lat < TIMEOUT * CLK_DIV - 1 || lat > TIMEOUT * CLK_DIV + 2) begin
            failures++;
            $display("FAIL tmo latency: got %0d expected about %0d", lat, TIMEOUT * CLK_DIV);
        end
        ok0 = ok_n;
        send_frame(vecs[0]);
        repeat (3 * CLK_DIV) @(negedge clock);
        check("post tmo ok", ok_n - ok0, 1);
        exp_cnt = (exp_cnt + 1) % 16;
        check("post tmo cnt", {28'd0, frame_cnt}, exp_cnt);

        // Reset in the middle of a payload byte
        send_byte(8'hA5, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        rx = 1'b0;
        repeat (12) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("mid rst wr_en",     {31'd0, wr_en},     32'd0);
        check("mid rst wr_addr",   {28'd0, wr_addr},   32'd0);
        check("mid rst wr_data",   {16'd0, wr_data},   32'd0);
        check("mid rst frame_ok",  {31'd0, frame_ok},  32'd0);
        check("mid rst frame_err", {31'd0, frame_err}, 32'd0);
        check("mid rst frame_cnt", {28'd0, frame_cnt}, 32'd0);
        ok0  = ok_n;
        err0 = err_n;
        rx   = 1'b1;
        repeat (20) @(negedge clock);
        reset = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clock);
        check("after rst ok",  ok_n - ok0,   0);
        check("after rst err", err_n - err0, 0);
        exp_cnt = 0;

        // 16 good frames: frame_cnt walks 1..F then wraps to 0
        ok0 = ok_n;
        for (int f = 0; f < 16; f++) begin
            send_frame(vecs[0]);
            repeat (3 * CLK_DIV) @(negedge clock);
            exp_cnt = (exp_cnt + 1) % 16;
            check($sformatf("wrap cnt %0d", f), {28'd0, frame_cnt}, exp_cnt);
        end
        check("wrap ok total", ok_n - ok0, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
